// File: rtl/ad9915_seq_pkg.sv
// ad9915_seq_pkg
// Shared definitions for the AD9915 sweep sequencer:
//   - seq_state_e     : sequencer FSM states (also exported on the debug port)
//   - FIELD_*         : field index within a profile's write/read address
//   - TIMEOUT_DEFAULT : default driver handshake timeout in clock cycles
//   - profile_t       : one ramp profile as presented to the DDS driver
// Optional feature macro used by the block: AD9915_SEQ_READBACK_EN.
package ad9915_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DWELL     = 3'd4,
    ST_ADVANCE   = 3'd5
  } seq_state_e;

  // Address layout is {profile, field}; fields 5..7 are unused.
  localparam logic [2:0] FIELD_LOWER     = 3'd0;
  localparam logic [2:0] FIELD_UPPER     = 3'd1;
  localparam logic [2:0] FIELD_STEP_UP   = 3'd2;
  localparam logic [2:0] FIELD_STEP_DOWN = 3'd3;
  localparam logic [2:0] FIELD_SLOPE     = 3'd4;  // {slope_down, slope_up}
  localparam logic [2:0] FIELD_LAST      = FIELD_SLOPE;

  localparam int TIMEOUT_DEFAULT = 65535;

  typedef struct packed {
    logic [31:0] lower;
    logic [31:0] upper;
    logic [31:0] step_up;
    logic [31:0] step_down;
    logic [15:0] slope_up;
    logic [15:0] slope_down;
  } profile_t;

endpackage

// File: rtl/ad9915_profile_table.sv
// ad9915_profile_table
// Register-based storage for NUM_PROFILES ramp profiles of five 32-bit fields.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (table clears to 0)
//   wr_en/wr_addr/
//   wr_data           : write port, wr_addr = {profile, field}; fields 5..7 dropped
//   rd_profile        : profile index for the parallel (combinational) read
//   rd_entry          : all fields of profile rd_profile
//   rb_addr/rb_data   : registered single-field readback, only when
//                       AD9915_SEQ_READBACK_EN is defined; fields 5..7 read 0
module ad9915_profile_table
  import ad9915_seq_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  localparam int PW = $clog2(NUM_PROFILES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW+2:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [PW-1:0] rd_profile,
`ifdef AD9915_SEQ_READBACK_EN
  input  logic [PW+2:0] rb_addr,
  output logic [31:0]   rb_data,
`endif
  output profile_t      rd_entry
);

  logic [31:0] mem_q [NUM_PROFILES][5];
  logic [31:0] mem_d [NUM_PROFILES][5];

  logic [PW-1:0] wr_prof;
  logic [2:0]    wr_field;

  assign wr_prof  = wr_addr[PW+2:3];
  assign wr_field = wr_addr[2:0];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && (wr_field <= FIELD_LAST)) begin
      mem_d[wr_prof][wr_field] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PROFILES; p++) begin
        for (int f = 0; f < 5; f++) begin
          mem_q[p][f] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_entry.lower      = mem_q[rd_profile][FIELD_LOWER];
    rd_entry.upper      = mem_q[rd_profile][FIELD_UPPER];
    rd_entry.step_up    = mem_q[rd_profile][FIELD_STEP_UP];
    rd_entry.step_down  = mem_q[rd_profile][FIELD_STEP_DOWN];
    rd_entry.slope_up   = mem_q[rd_profile][FIELD_SLOPE][15:0];
    rd_entry.slope_down = mem_q[rd_profile][FIELD_SLOPE][31:16];
  end

`ifdef AD9915_SEQ_READBACK_EN
  logic [PW-1:0] rb_prof;
  logic [2:0]    rb_field;
  logic [31:0]   rb_data_d;
  logic [31:0]   rb_data_q;

  assign rb_prof  = rb_addr[PW+2:3];
  assign rb_field = rb_addr[2:0];

  always_comb begin
    rb_data_d = '0;
    if (rb_field <= FIELD_LAST) begin
      rb_data_d = mem_q[rb_prof][rb_field];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data_q <= '0;
    end else begin
      rb_data_q <= rb_data_d;
    end
  end

  assign rb_data = rb_data_q;
`endif

endmodule

// File: rtl/ad9915_sweep_sequencer.sv
// ad9915_sweep_sequencer
// Steps an AD9915 DDS driver through a table of ramp profiles. For each
// profile it loads the parameters, handshakes with the driver (opUpdate until
// ipDriverBusy rises, then waits for it to fall), holds opTrigger high for
// max(ipDwell,1) cycles, then advances, wraps (ipRepeat) or stops.
// Ports:
//   ipClk, ipnReset            : clock, asynchronous active-low reset
//   ipWrEnable/ipWrAddress/
//   ipWrData                   : profile table write, address {profile, field}
//   ipStart, ipStop            : sequence start / abort pulses (stop wins)
//   ipRepeat, ipLastProfile    : wrap enable, final profile (sampled at start)
//   ipDwell                    : trigger-high cycles per profile
//   op* parameter outputs      : registered profile parameters for the driver
//   opUpdate, ipDriverBusy     : driver handshake
//   opTrigger                  : ramp trigger
//   opBusy, opProfile, opError : status; opError is a sticky handshake timeout
//   opDbgState                 : current FSM state, for observation only
//   ipRdAddress, opRdData      : registered table readback, only present when
//                                AD9915_SEQ_READBACK_EN is defined
// Handshake: opUpdate is raised with stable parameters and held until the
// driver shows ipDriverBusy=1; the ramp is triggered once ipDriverBusy
// returns to 0. Either wait aborts to Idle with opError after TIMEOUT_CYCLES.
module ad9915_sweep_sequencer
  import ad9915_seq_pkg::*;
#(
  parameter int NUM_PROFILES   = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int PW = $clog2(NUM_PROFILES)
) (
  input  logic          ipClk,
  input  logic          ipnReset,
  input  logic          ipWrEnable,
  input  logic [PW+2:0] ipWrAddress,
  input  logic [31:0]   ipWrData,
  input  logic          ipStart,
  input  logic          ipStop,
  input  logic          ipRepeat,
  input  logic [PW-1:0] ipLastProfile,
  input  logic [23:0]   ipDwell,
  output logic [31:0]   opFreqLowerLimit,
  output logic [31:0]   opFreqUpperLimit,
  output logic [31:0]   opStepUp,
  output logic [31:0]   opStepDown,
  output logic [15:0]   opSlopeUp,
  output logic [15:0]   opSlopeDown,
  output logic          opUpdate,
  input  logic          ipDriverBusy,
  output logic          opTrigger,
  output logic          opBusy,
  output logic [PW-1:0] opProfile,
  output logic          opError,
`ifdef AD9915_SEQ_READBACK_EN
  input  logic [PW+2:0] ipRdAddress,
  output logic [31:0]   opRdData,
`endif
  output seq_state_e    opDbgState
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  seq_state_e    state_q,   state_d;
  logic [PW-1:0] profile_q, profile_d;
  logic [PW-1:0] last_q,    last_d;
  logic          busy_q,    busy_d;
  logic          update_q,  update_d;
  logic          trigger_q, trigger_d;
  logic          error_q,   error_d;
  profile_t      params_q,  params_d;
  logic [23:0]   dwell_q,   dwell_d;
  logic [31:0]   tmo_q,     tmo_d;

  profile_t      tbl_entry;
  logic          tmo_expired;

  ad9915_profile_table #(
    .NUM_PROFILES (NUM_PROFILES)
  ) u_table (
    .clk        (ipClk),
    .rst_n      (ipnReset),
    .wr_en      (ipWrEnable),
    .wr_addr    (ipWrAddress),
    .wr_data    (ipWrData),
    .rd_profile (profile_q),
`ifdef AD9915_SEQ_READBACK_EN
    .rb_addr    (ipRdAddress),
    .rb_data    (opRdData),
`endif
    .rd_entry   (tbl_entry)
  );

  // tmo_q counts cycles spent in the current state, so expiry on its last
  // value means exactly TIMEOUT_CYCLES cycles of waiting.
  assign tmo_expired = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    profile_d = profile_q;
    last_d    = last_q;
    busy_d    = busy_q;
    update_d  = update_q;
    trigger_d = trigger_q;
    error_d   = error_q;
    params_d  = params_q;
    dwell_d   = dwell_q;

    case (state_q)
      ST_IDLE: begin
        if (ipStart && !ipStop) begin
          profile_d = '0;
          last_d    = ipLastProfile;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Parameters are captured here, so table writes made later in the
        // sequence only show up at this profile's next load.
        params_d = tbl_entry;
        update_d = 1'b1;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ipDriverBusy) begin
          update_d = 1'b0;
          state_d  = ST_WAIT_DONE;
        end else if (tmo_expired) begin
          update_d = 1'b0;
          error_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!ipDriverBusy) begin
          trigger_d = 1'b1;
          dwell_d   = ipDwell;
          state_d   = ST_DWELL;
        end else if (tmo_expired) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DWELL: begin
        // Trigger is high for every Dwell cycle; leaving when the count is
        // 1 (or was loaded as 0) gives max(ipDwell,1) high cycles.
        if (dwell_q <= 24'd1) begin
          trigger_d = 1'b0;
          state_d   = ST_ADVANCE;
        end else begin
          dwell_d = dwell_q - 24'd1;
        end
      end
      ST_ADVANCE: begin
        if (profile_q == last_q) begin
          if (ipRepeat) begin
            profile_d = '0;
            state_d   = ST_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          profile_d = profile_q + 1'b1;
          state_d   = ST_LOAD;
        end
      end
      default: begin
        update_d  = 1'b0;
        trigger_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (ipStop) begin
      update_d  = 1'b0;
      trigger_d = 1'b0;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (tmo_expired) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state_q   <= ST_IDLE;
      profile_q <= '0;
      last_q    <= '0;
      busy_q    <= 1'b0;
      update_q  <= 1'b0;
      trigger_q <= 1'b0;
      error_q   <= 1'b0;
      params_q  <= '0;
      dwell_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      profile_q <= profile_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      update_q  <= update_d;
      trigger_q <= trigger_d;
      error_q   <= error_d;
      params_q  <= params_d;
      dwell_q   <= dwell_d;
      tmo_q     <= tmo_d;
    end
  end

  assign opFreqLowerLimit = params_q.lower;
  assign opFreqUpperLimit = params_q.upper;
  assign opStepUp         = params_q.step_up;
  assign opStepDown       = params_q.step_down;
  assign opSlopeUp        = params_q.slope_up;
  assign opSlopeDown      = params_q.slope_down;
  assign opUpdate         = update_q;
  assign opTrigger        = trigger_q;
  assign opBusy           = busy_q;
  assign opProfile        = profile_q;
  assign opError          = error_q;
  assign opDbgState       = state_q;

endmodule

// File: tb/tb_ad9915_sweep_sequencer.sv
// Testbench for ad9915_sweep_sequencer (NUM_PROFILES=4, TIMEOUT_CYCLES=50).
module tb_ad9915_sweep_sequencer;
  import ad9915_seq_pkg::*;

  localparam int NP  = 4;
  localparam int PW  = 2;
  localparam int TMO = 50;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ipWrEnable = 1'b0;
  logic [PW+2:0] ipWrAddress = '0;
  logic [31:0]   ipWrData = '0;
  logic          ipStart = 1'b0;
  logic          ipStop = 1'b0;
  logic          ipRepeat = 1'b0;
  logic [PW-1:0] ipLastProfile = '0;
  logic [23:0]   ipDwell = '0;
  logic          ipDriverBusy = 1'b0;
  logic [31:0]   opFreqLowerLimit, opFreqUpperLimit, opStepUp, opStepDown;
  logic [15:0]   opSlopeUp, opSlopeDown;
  logic          opUpdate, opTrigger, opBusy, opError;
  logic [PW-1:0] opProfile;
  seq_state_e    opDbgState;
`ifdef AD9915_SEQ_READBACK_EN
  logic [PW+2:0] ipRdAddress = '0;
  logic [31:0]   opRdData;
`endif

  ad9915_sweep_sequencer #(.NUM_PROFILES(NP), .TIMEOUT_CYCLES(TMO)) dut (
    .ipClk(clk), .ipnReset(rst_n),
    .ipWrEnable(ipWrEnable), .ipWrAddress(ipWrAddress), .ipWrData(ipWrData),
    .ipStart(ipStart), .ipStop(ipStop), .ipRepeat(ipRepeat),
    .ipLastProfile(ipLastProfile), .ipDwell(ipDwell),
    .opFreqLowerLimit(opFreqLowerLimit), .opFreqUpperLimit(opFreqUpperLimit),
    .opStepUp(opStepUp), .opStepDown(opStepDown),
    .opSlopeUp(opSlopeUp), .opSlopeDown(opSlopeDown),
    .opUpdate(opUpdate), .ipDriverBusy(ipDriverBusy), .opTrigger(opTrigger),
    .opBusy(opBusy), .opProfile(opProfile), .opError(opError),
`ifdef AD9915_SEQ_READBACK_EN
    .ipRdAddress(ipRdAddress), .opRdData(opRdData),
`endif
    .opDbgState(opDbgState)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference table: what each profile field should hold.
  logic [31:0] tbl_m [NP][5];
  // Expected profile index of each upcoming driver update, in order.
  logic [PW-1:0] exp_q[$];
  int upd_seen = 0;
  int trig_seen = 0;
  int trig_len = 0;
  int exp_trig = 1;
  bit skip_trig = 1'b0;
  bit prev_upd = 1'b0;
  bit prev_trig = 1'b0;

  // Monitor: every new update request must carry the next expected profile
  // and that profile's current table contents; every trigger pulse must last
  // exp_trig cycles.
  always @(negedge clk) begin
    logic [PW-1:0] p;
    logic [31:0] slope;
    if (opUpdate && !prev_upd) begin
      upd_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: got profile %0d, expected no update", opProfile);
      end else begin
        p = exp_q.pop_front();
        slope = tbl_m[p][4];
        check("upd_profile", 64'(opProfile), 64'(p));
        check("upd_lower", 64'(opFreqLowerLimit), 64'(tbl_m[p][0]));
        check("upd_upper", 64'(opFreqUpperLimit), 64'(tbl_m[p][1]));
        check("upd_step_up", 64'(opStepUp), 64'(tbl_m[p][2]));
        check("upd_step_down", 64'(opStepDown), 64'(tbl_m[p][3]));
        check("upd_slope_up", 64'(opSlopeUp), 64'(slope[15:0]));
        check("upd_slope_down", 64'(opSlopeDown), 64'(slope[31:16]));
      end
    end
    if (opTrigger) trig_len++;
    if (!opTrigger && prev_trig) begin
      trig_seen++;
      if (!skip_trig) check("trig_len", 64'(trig_len), 64'(exp_trig));
      trig_len = 0;
    end
    prev_upd = opUpdate;
    prev_trig = opTrigger;
  end

  // Driver model: mode 0 acks after 0..3 cycles and stays busy 1..4 cycles,
  // mode 1 never acks, mode 2 acks and never finishes.
  int drv_mode = 0;
  int drv_phase = 0;
  int drv_cnt = 0;
  always @(negedge clk) begin
    case (drv_mode)
      1: ipDriverBusy = 1'b0;
      2: if (opUpdate) ipDriverBusy = 1'b1;
      default: begin
        if (drv_phase == 0) begin
          if (opUpdate) begin
            if (drv_cnt <= 0) begin
              ipDriverBusy = 1'b1;
              drv_cnt = $urandom_range(1, 4);
              drv_phase = 1;
            end else begin
              drv_cnt--;
            end
          end
        end else begin
          drv_cnt--;
          if (drv_cnt <= 0) begin
            ipDriverBusy = 1'b0;
            drv_phase = 0;
            drv_cnt = $urandom_range(0, 3);
          end
        end
      end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic write_field(input int p, input int f, input logic [31:0] d);
    @(negedge clk);
    ipWrEnable = 1'b1;
    ipWrAddress = 5'(p * 8 + f);
    ipWrData = d;
    @(negedge clk);
    ipWrEnable = 1'b0;
    if (f <= 4) tbl_m[p][f] = d;
  endtask

  task automatic start_seq(input int last, input int rep, input int dwell);
    @(negedge clk);
    ipLastProfile = PW'(last);
    ipRepeat = rep[0];
    ipDwell = 24'(dwell);
    ipStart = 1'b1;
    @(negedge clk);
    ipStart = 1'b0;
    // Changing this after start must not affect the running sequence.
    ipLastProfile = PW'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while (opBusy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(opBusy), 64'd0);
  endtask

  task automatic stop_after_trig(input int n, input string name);
    int i = 0;
    while (trig_seen < n && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(trig_seen >= n), 64'd1);
    ipStop = 1'b1;
    @(negedge clk);
    ipStop = 1'b0;
    check({name, "_stopped"}, 64'(opBusy), 64'd0);
  endtask

  task automatic wait_update(input string name);
    int i = 0;
    while (!opUpdate && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(opUpdate), 64'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int last;
    int rep;
    int dwell;
    int n_obs;     // updates/triggers to observe
    int exp_trig;  // expected trigger length
    int exp_upd;   // expected update count
  } vec_t;
  vec_t vecs[5];

  initial begin
    int last, dwell, i, cnt;

    vecs[0] = '{0, 0, 100, 1, 100, 1};
    vecs[1] = '{2, 1, 10, 7, 10, 7};
    vecs[2] = '{0, 0, 0, 1, 1, 1};
    vecs[3] = '{3, 0, 1, 4, 1, 4};
    vecs[4] = '{1, 0, 5, 2, 5, 2};
    for (int p = 0; p < NP; p++) for (int f = 0; f < 5; f++) tbl_m[p][f] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_update", 64'(opUpdate), 64'd0);
    check("rst_trigger", 64'(opTrigger), 64'd0);
    check("rst_busy", 64'(opBusy), 64'd0);
    check("rst_error", 64'(opError), 64'd0);
    check("rst_profile", 64'(opProfile), 64'd0);
    check("rst_state", 64'(opDbgState), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Table contents: profile 0 from the reference case, others random,
    // plus junk to the unused fields which must change nothing.
    write_field(0, 0, 32'h1000);
    write_field(0, 1, 32'h2000);
    write_field(0, 2, 32'h10);
    write_field(0, 3, 32'h20);
    write_field(0, 4, 32'h0003_0004);
    for (int p = 1; p < NP; p++) for (int f = 0; f < 5; f++) write_field(p, f, $urandom);
    for (int f = 5; f < 8; f++) write_field(0, f, $urandom);

    // Table-driven sequences
    for (int v = 0; v < 5; v++) begin
      upd_seen = 0;
      trig_seen = 0;
      exp_trig = vecs[v].exp_trig;
      for (int k = 0; k < vecs[v].n_obs; k++) exp_q.push_back(PW'(k % (vecs[v].last + 1)));
      start_seq(vecs[v].last, vecs[v].rep, vecs[v].dwell);
      if (vecs[v].rep == 0) wait_idle(5000, "vec_done");
      else stop_after_trig(vecs[v].n_obs, "vec_rep");
      check("vec_updates", 64'(upd_seen), 64'(vecs[v].exp_upd));
      check("vec_triggers", 64'(trig_seen), 64'(vecs[v].exp_upd));
      check("vec_queue_empty", 64'(exp_q.size()), 64'd0);
      check("vec_state", 64'(opDbgState), 64'(ST_IDLE));
    end

    // Randomized sequences against the reference table
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 6; k++) write_field($urandom_range(0, NP - 1), $urandom_range(0, 7), $urandom);
      last = $urandom_range(0, NP - 1);
      dwell = $urandom_range(0, 12);
      upd_seen = 0;
      trig_seen = 0;
      exp_trig = (dwell == 0) ? 1 : dwell;
      for (int k = 0; k <= last; k++) exp_q.push_back(PW'(k));
      start_seq(last, 0, dwell);
      wait_idle(5000, "rand_done");
      check("rand_updates", 64'(upd_seen), 64'(last + 1));
      check("rand_triggers", 64'(trig_seen), 64'(last + 1));
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    end

`ifdef AD9915_SEQ_READBACK_EN
    @(negedge clk);
    ipRdAddress = 5'(2 * 8 + 1);
    @(negedge clk);
    check("rb_field", 64'(opRdData), 64'(tbl_m[2][1]));
    ipRdAddress = 5'(1 * 8 + 6);
    @(negedge clk);
    check("rb_unused_field", 64'(opRdData), 64'd0);
`endif

    // Table write during a repeating sequence reaches the next load
    upd_seen = 0;
    trig_seen = 0;
    exp_trig = 20;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    start_seq(1, 1, 20);
    i = 0;
    while (!(opProfile == 2'd1 && opTrigger) && i < 500) begin @(negedge clk); i++; end
    check("wr_mid_reach_p1", 64'(opProfile == 2'd1 && opTrigger), 64'd1);
    write_field(0, 0, 32'hCAFE_0001);
    stop_after_trig(3, "wr_mid");
    check("wr_mid_updates", 64'(upd_seen), 64'd3);

    // Stop during Dwell of profile 1, then restart at profile 0
    upd_seen = 0;
    trig_seen = 0;
    exp_trig = 30;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    start_seq(3, 0, 30);
    i = 0;
    while (!(opProfile == 2'd1 && opTrigger) && i < 500) begin @(negedge clk); i++; end
    check("stop_reach_p1", 64'(opProfile == 2'd1 && opTrigger), 64'd1);
    skip_trig = 1'b1;
    ipStop = 1'b1;
    @(negedge clk);
    ipStop = 1'b0;
    check("stop_trigger", 64'(opTrigger), 64'd0);
    check("stop_busy", 64'(opBusy), 64'd0);
    check("stop_state", 64'(opDbgState), 64'(ST_IDLE));
    check("stop_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    skip_trig = 1'b0;
    upd_seen = 0;
    exp_trig = 4;
    exp_q.push_back(2'd0);
    start_seq(0, 0, 4);
    wait_idle(500, "restart_done");
    check("restart_updates", 64'(upd_seen), 64'd1);

    // Stop beats a simultaneous start
    @(negedge clk);
    ipStart = 1'b1;
    ipStop = 1'b1;
    @(negedge clk);
    ipStart = 1'b0;
    ipStop = 1'b0;
    check("stop_prio_busy", 64'(opBusy), 64'd0);
    check("stop_prio_state", 64'(opDbgState), 64'(ST_IDLE));

    // Ack timeout: driver never responds
    drv_mode = 1;
    exp_q.push_back(2'd0);
    start_seq(0, 0, 3);
    wait_update("tmo_ack_update");
    cnt = 0;
    while (opUpdate && cnt < 200) begin cnt++; @(negedge clk); end
    check("tmo_ack_cycles", 64'(cnt), 64'(TMO));
    check("tmo_ack_error", 64'(opError), 64'd1);
    check("tmo_ack_update_low", 64'(opUpdate), 64'd0);
    check("tmo_ack_busy", 64'(opBusy), 64'd0);
    check("tmo_ack_state", 64'(opDbgState), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    check("tmo_error_sticky", 64'(opError), 64'd1);
    drv_mode = 0;
    drv_phase = 0;
    drv_cnt = 0;
    exp_trig = 3;
    exp_q.push_back(2'd0);
    start_seq(0, 0, 3);
    check("start_clears_error", 64'(opError), 64'd0);
    check("start_sets_busy", 64'(opBusy), 64'd1);
    wait_idle(500, "post_tmo_done");

    // Done timeout: driver stays busy
    drv_mode = 2;
    exp_q.push_back(2'd0);
    start_seq(0, 0, 3);
    wait_idle(300, "tmo_done_idle");
    check("tmo_done_error", 64'(opError), 64'd1);
    check("tmo_done_trigger", 64'(opTrigger), 64'd0);
    check("tmo_done_state", 64'(opDbgState), 64'(ST_IDLE));
    drv_mode = 0;
    drv_phase = 0;
    drv_cnt = 0;
    ipDriverBusy = 1'b0;

    // Reset in WaitAck drops everything at once and clears the table
    drv_mode = 1;
    exp_q.push_back(2'd0);
    start_seq(0, 0, 3);
    wait_update("rst_mid_update");
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_update_low", 64'(opUpdate), 64'd0);
    check("rst_mid_trigger", 64'(opTrigger), 64'd0);
    check("rst_mid_busy", 64'(opBusy), 64'd0);
    check("rst_mid_error", 64'(opError), 64'd0);
    check("rst_mid_profile", 64'(opProfile), 64'd0);
    check("rst_mid_state", 64'(opDbgState), 64'(ST_IDLE));
    for (int p = 0; p < NP; p++) for (int f = 0; f < 5; f++) tbl_m[p][f] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drv_mode = 0;
    drv_phase = 0;
    drv_cnt = 0;
`ifdef AD9915_SEQ_READBACK_EN
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      ipRdAddress = 5'(a * 4 + 1);
      @(negedge clk);
      check("rb_after_reset", 64'(opRdData), 64'd0);
    end
`endif
    // A full sequence after reset must load all-zero parameters
    upd_seen = 0;
    exp_trig = 2;
    for (int k = 0; k < NP; k++) exp_q.push_back(PW'(k));
    start_seq(NP - 1, 0, 2);
    wait_idle(2000, "post_rst_done");
    check("post_rst_updates", 64'(upd_seen), 64'(NP));

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected test completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9915_sweep_sequencer.md
AD9915_SWEEP_SEQUENCER -- requirements
Module: ad9915_sweep_sequencer

Interface
REQ-001 SHALL have parameter NUM_PROFILES, default 4: number of ramp profiles held (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum wait for any driver handshake edge.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have the ports below.
- ipClk  in  1  system clock
- ipnReset  in  1  asynchronous active-low reset
- ipWrEnable  in  1  table write strobe
- ipWrAddress  in  log2(NUM_PROFILES)+3  {profile, field}; field 0 = lower, 1 = upper, 2 = step up, 3 = step down, 4 = {slope down, slope up}; fields 5..7 ignored
- ipWrData  in  32  table write data
- ipStart  in  1  start-sequence pulse
- ipStop  in  1  abort pulse
- ipRepeat  in  1  wrap to profile 0 after the last profile
- ipLastProfile  in  log2(NUM_PROFILES)  index of the final profile in the sequence
- ipDwell  in  24  trigger-high cycles per profile
- opFreqLowerLimit, opFreqUpperLimit, opStepUp, opStepDown  out  32  to driver
- opSlopeUp, opSlopeDown  out  16  to driver
- opUpdate  out  1  driver update request
- ipDriverBusy  in  1  driver busy
- opTrigger  out  1  driver ramp trigger
- opBusy  out  1  sequence active
- opProfile  out  log2(NUM_PROFILES)  current profile index
- opError  out  1  sticky handshake timeout

Function
REQ-005 SHALL write ipWrData into the table on ipWrEnable; a write during a sequence SHALL take effect at that profile's next load.
REQ-006 SHALL implement states Idle, Load, WaitAck, WaitDone, Dwell, Advance.
REQ-007 Idle: on ipStart, SHALL set opProfile=0, opBusy=1 and go to Load next cycle.
REQ-008 Load: SHALL drive all driver parameter outputs from the table entry opProfile, set opUpdate=1 and go to WaitAck.
REQ-009 WaitAck: SHALL hold opUpdate=1 until ipDriverBusy=1, then clear opUpdate and go to WaitDone.
REQ-010 WaitDone: on ipDriverBusy=0, SHALL set opTrigger=1, load the dwell counter with ipDwell and go to Dwell.
REQ-011 Dwell: SHALL decrement the counter each cycle; at 0 SHALL clear opTrigger and go to Advance. Trigger-high time SHALL be exactly max(ipDwell,1) cycles.
REQ-012 Advance: if opProfile==ipLastProfile and ipRepeat=1, SHALL go to profile 0 and Load.
REQ-013 Advance: if opProfile==ipLastProfile and ipRepeat=0, SHALL go to Idle with opBusy=0.
REQ-014 Advance: otherwise SHALL increment opProfile and go to Load.
REQ-015 ipStop in any state SHALL clear opUpdate and opTrigger and go to Idle with opBusy=0 next cycle; ipStop SHALL take priority over a simultaneous ipStart.
REQ-016 ipStart outside Idle SHALL be ignored.
REQ-017 A timeout counter SHALL reset on each state entry; if it reaches TIMEOUT_CYCLES in WaitAck or WaitDone, the block SHALL set opError=1, clear opUpdate and go to Idle.
REQ-018 opError SHALL clear only on reset or on the next accepted ipStart.
REQ-019 ipLastProfile SHALL be sampled at ipStart and held for the sequence.

Reset
REQ-020 On ipnReset low, opUpdate, opTrigger, opBusy and opError SHALL be 0, opProfile SHALL be 0, the state SHALL be Idle and the table SHALL be all zero.
REQ-021 Reset mid-sequence SHALL drop opTrigger and opUpdate asynchronously.

Configuration
REQ-022 With AD9915_SEQ_READBACK_EN defined, the block SHALL add ports ipRdAddress (same width as ipWrAddress) and opRdData (32 bits); opRdData SHALL be valid one cycle after ipRdAddress and read 0 for fields 5..7.
REQ-023 Without AD9915_SEQ_READBACK_EN, those ports and the read logic SHALL be absent.

Structure
REQ-024 The state enum, field index constants and TIMEOUT default SHALL live in package ad9915_seq_pkg.
REQ-025 The profile storage SHALL be sub-module ad9915_profile_table (write port, profile-indexed parallel read, optional readback port).

Verification
REQ-026 Write profile 0 = (0x1000,0x2000,0x10,0x20,0x00030004), ipLastProfile=0, ipRepeat=0, ipDwell=100, ipStart -> one opUpdate handshake, outputs match, opTrigger high exactly 100 cycles, then opBusy=0.
REQ-027 ipLastProfile=2, ipRepeat=1, ipDwell=10 -> opProfile cycles 0,1,2,0,...; each profile has one update and one 10-cycle trigger.
REQ-028 ipStop asserted during Dwell of profile 1 -> opTrigger=0 and opBusy=0 the next cycle; a later ipStart restarts at profile 0.
REQ-029 ipDriverBusy tied 0, TIMEOUT_CYCLES=50 -> opError=1 at 50 cycles after Load, opUpdate=0, state Idle; a following ipStart clears opError.
REQ-030 Reset pulse during WaitAck -> all outputs at reset values immediately; the table reads zero (readback build).
REQ-031 ipStart with ipDwell=0 -> trigger high for 1 cycle.
